// File: rtl/mdu_issue_tracker.sv
// Issue/completion tracker for the M-extension unit: MUL/DIV metadata pipes plus rd busy scoreboard.
// Optional build macro MDU_TRACKER_BYPASS_EN: an issue may depend on the register retiring this cycle.
module mdu_issue_tracker #(
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 8,
  parameter int NUM_REGS = 32,
  parameter int RD_W     = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic                issue_is_mul,
  input  logic [2:0]          issue_funct3,
  input  logic [RD_W-1:0]     issue_rd,
  input  logic [RD_W-1:0]     issue_rs1,
  input  logic [RD_W-1:0]     issue_rs2,
  output logic                issue_ready,
  input  logic                flush,
  input  logic                wb_ready,
  output logic                wb_valid,
  output logic                wb_is_mul,
  output logic [2:0]          wb_funct3,
  output logic [RD_W-1:0]     wb_rd,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                mdu_busy
);

  // A MUL issued now would land on the same writeback cycle as a DIV sitting in this stage.
  localparam int SLOT_STG = DIV_LAT - MUL_LAT - 1;

  logic [MUL_LAT-1:0]  mul_v_q, mul_v_d;
  logic [2:0]          mul_f3_q [MUL_LAT];
  logic [2:0]          mul_f3_d [MUL_LAT];
  logic [RD_W-1:0]     mul_rd_q [MUL_LAT];
  logic [RD_W-1:0]     mul_rd_d [MUL_LAT];
  logic [DIV_LAT-1:0]  div_v_q, div_v_d;
  logic [2:0]          div_f3_q [DIV_LAT];
  logic [2:0]          div_f3_d [DIV_LAT];
  logic [RD_W-1:0]     div_rd_q [DIV_LAT];
  logic [RD_W-1:0]     div_rd_d [DIV_LAT];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] busy_chk, set_mask, ret_mask;
  logic                mul_last, div_last, stall, retire, hazard, accept;

  assign mul_last  = mul_v_q[MUL_LAT-1];
  assign div_last  = div_v_q[DIV_LAT-1];
  assign wb_valid  = mul_last | div_last;
  assign wb_is_mul = mul_last;
  assign wb_funct3 = mul_last ? mul_f3_q[MUL_LAT-1] : (div_last ? div_f3_q[DIV_LAT-1] : 3'd0);
  assign wb_rd     = mul_last ? mul_rd_q[MUL_LAT-1] : (div_last ? div_rd_q[DIV_LAT-1] : '0);
  assign busy_vec  = busy_q;
  assign mdu_busy  = (|mul_v_q) | (|div_v_q);

  assign stall  = wb_valid & ~wb_ready;
  assign retire = wb_valid & wb_ready;

  always_comb begin
    ret_mask = '0;
    if (retire && (wb_rd != '0)) ret_mask[wb_rd] = 1'b1;
  end

`ifdef MDU_TRACKER_BYPASS_EN
  assign busy_chk = busy_q & ~ret_mask;
`else
  assign busy_chk = busy_q;
`endif

  assign hazard = ((issue_rs1 != '0) & busy_chk[issue_rs1]) |
                  ((issue_rs2 != '0) & busy_chk[issue_rs2]) |
                  ((issue_rd  != '0) & busy_chk[issue_rd])  |
                  (issue_is_mul & div_v_q[SLOT_STG]);

  assign issue_ready = ~stall & ~flush & ~hazard;
  assign accept      = issue_valid & issue_ready;

  always_comb begin
    set_mask = '0;
    if (accept && (issue_rd != '0)) set_mask[issue_rd] = 1'b1;
  end

  always_comb begin
    mul_v_d  = mul_v_q;
    mul_f3_d = mul_f3_q;
    mul_rd_d = mul_rd_q;
    div_v_d  = div_v_q;
    div_f3_d = div_f3_q;
    div_rd_d = div_rd_q;
    busy_d   = busy_q;
    if (flush) begin
      mul_v_d = '0;
      div_v_d = '0;
      busy_d  = '0;
    end else if (!stall) begin
      for (int k = MUL_LAT - 1; k > 0; k--) begin
        mul_v_d[k]  = mul_v_q[k-1];
        mul_f3_d[k] = mul_f3_q[k-1];
        mul_rd_d[k] = mul_rd_q[k-1];
      end
      for (int k = DIV_LAT - 1; k > 0; k--) begin
        div_v_d[k]  = div_v_q[k-1];
        div_f3_d[k] = div_f3_q[k-1];
        div_rd_d[k] = div_rd_q[k-1];
      end
      mul_v_d[0]  = accept & issue_is_mul;
      mul_f3_d[0] = issue_funct3;
      mul_rd_d[0] = issue_rd;
      div_v_d[0]  = accept & ~issue_is_mul;
      div_f3_d[0] = issue_funct3;
      div_rd_d[0] = issue_rd;
      // Clear before set so an op re-targeting the retiring rd keeps the bit.
      busy_d = (busy_q & ~ret_mask) | set_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_v_q <= '0;
      div_v_q <= '0;
      busy_q  <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        mul_f3_q[k] <= '0;
        mul_rd_q[k] <= '0;
      end
      for (int k = 0; k < DIV_LAT; k++) begin
        div_f3_q[k] <= '0;
        div_rd_q[k] <= '0;
      end
    end else begin
      mul_v_q  <= mul_v_d;
      mul_f3_q <= mul_f3_d;
      mul_rd_q <= mul_rd_d;
      div_v_q  <= div_v_d;
      div_f3_q <= div_f3_d;
      div_rd_q <= div_rd_d;
      busy_q   <= busy_d;
    end
  end

  a_no_wb_collision: assert property (@(posedge clk) disable iff (!rst_n) !(mul_last && div_last));

endmodule

// File: tb/tb_mdu_issue_tracker.sv
// Bench for mdu_issue_tracker: vector table plus directed multi-cycle sequences, scoreboarded writebacks.
module tb_mdu_issue_tracker;

  localparam bit BYP =
`ifdef MDU_TRACKER_BYPASS_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_is_mul;
  logic [2:0]  issue_funct3;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_ready;
  logic        flush, wb_ready;
  logic        wb_valid, wb_is_mul;
  logic [2:0]  wb_funct3;
  logic [4:0]  wb_rd;
  logic [31:0] busy_vec;
  logic        mdu_busy;

  mdu_issue_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_is_mul(issue_is_mul), .issue_funct3(issue_funct3),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_ready(issue_ready), .flush(flush), .wb_ready(wb_ready),
    .wb_valid(wb_valid), .wb_is_mul(wb_is_mul), .wb_funct3(wb_funct3), .wb_rd(wb_rd),
    .busy_vec(busy_vec), .mdu_busy(mdu_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_mul;
    logic [2:0] f3;
    logic [4:0] rd;
  } wb_t;

  typedef struct {
    logic        is_mul;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    int          lat;
    logic [31:0] busy;
  } vec_t;

  wb_t  sb[$];
  vec_t tbl[6];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_is_mul = 1'b0; issue_funct3 = 3'd0;
    issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
  endtask

  task automatic present(input logic m, input logic [2:0] f, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic v);
    issue_valid = v; issue_is_mul = m; issue_funct3 = f;
    issue_rd = rd; issue_rs1 = r1; issue_rs2 = r2;
  endtask

  task automatic push(input logic m, input logic [2:0] f, input logic [4:0] rd);
    wb_t e;
    e.is_mul = m; e.f3 = f; e.rd = rd;
    sb.push_back(e);
  endtask

  // Writeback monitor: every retiring result must match the oldest expected entry.
  always @(negedge clk) begin
    #2;
    if (rst_n && wb_valid && wb_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_wb", 64'(wb_valid), 64'd0);
      else begin
        wb_t e;
        e = sb.pop_front();
        chk("sb_wb_fields", 64'({wb_is_mul, wb_funct3, wb_rd}), 64'(e));
      end
    end
  end

  // Dependent op on rd 3 of an in-flight MUL; returns once the dependent op has drained.
  task automatic hazard_seq(input logic [4:0] dep_rs1, input logic [4:0] dep_rd);
    bit acc;
    present(1'b1, 3'd0, 5'd3, 5'd0, 5'd0, 1'b1);
    #1 chk("haz_first_ready", 64'(issue_ready), 64'd1);
    push(1'b1, 3'd0, 5'd3);
    acc = 1'b0;
    for (int k = 1; k <= 8 && !acc; k++) begin
      bit exp;
      @(negedge clk);
      present(1'b1, 3'd2, dep_rd, dep_rs1, 5'd0, 1'b1);
      exp = (k >= 5) || (BYP && k == 4);
      #1 chk("haz_dep_ready", 64'(issue_ready), 64'(exp));
      if (exp) begin
        push(1'b1, 3'd2, dep_rd);
        acc = 1'b1;
      end
    end
    @(negedge clk);
    idle();
    #1 chk("haz_busy_after", 64'(busy_vec), 64'd1 << dep_rd);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    bit seen;
    tbl[0] = '{1'b1, 3'd0, 5'd5,  5'd1, 5'd2, 4, 32'h0000_0020};
    tbl[1] = '{1'b0, 3'd4, 5'd7,  5'd5, 5'd6, 8, 32'h0000_0080};
    tbl[2] = '{1'b1, 3'd1, 5'd0,  5'd7, 5'd0, 4, 32'h0000_0000};
    tbl[3] = '{1'b0, 3'd7, 5'd31, 5'd3, 5'd4, 8, 32'h8000_0000};
    tbl[4] = '{1'b1, 3'd3, 5'd1,  5'd0, 5'd31, 4, 32'h0000_0002};
    tbl[5] = '{1'b0, 3'd6, 5'd0,  5'd9, 5'd9, 8, 32'h0000_0000};

    rst_n = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_meta",  64'({wb_is_mul, wb_funct3, wb_rd}), 64'd0);
    chk("rst_busy_vec", 64'(busy_vec), 64'd0);
    chk("rst_mdu_busy", 64'(mdu_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("rst_issue_ready", 64'(issue_ready), 64'd1);

    // Single ops, one at a time: latency, busy window, metadata.
    foreach (tbl[i]) begin
      @(negedge clk);
      present(tbl[i].is_mul, tbl[i].f3, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, 1'b1);
      #1 chk("tbl_ready", 64'(issue_ready), 64'd1);
      push(tbl[i].is_mul, tbl[i].f3, tbl[i].rd);
      for (int k = 1; k <= tbl[i].lat + 1; k++) begin
        @(negedge clk);
        if (k == 1) idle();
        #1;
        chk("tbl_wb_valid", 64'(wb_valid), 64'(k == tbl[i].lat));
        chk("tbl_busy_vec", 64'(busy_vec), (k <= tbl[i].lat) ? 64'(tbl[i].busy) : 64'd0);
        chk("tbl_mdu_busy", 64'(mdu_busy), 64'(k <= tbl[i].lat));
      end
    end

    // rd=0 op followed by rs1=0 consumer.
    @(negedge clk);
    present(1'b1, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    #1 chk("rd0_ready", 64'(issue_ready), 64'd1);
    push(1'b1, 3'd0, 5'd0);
    @(negedge clk);
    present(1'b0, 3'd5, 5'd9, 5'd0, 5'd0, 1'b1);
    #1 chk("rd0_dep_ready", 64'(issue_ready), 64'd1);
    push(1'b0, 3'd5, 5'd9);
    @(negedge clk);
    idle();
    #1 chk("rd0_busy", 64'(busy_vec), 64'h200);
    repeat (9) @(negedge clk);

    // DIV then MUL: writeback-slot collision.
    @(negedge clk);
    present(1'b0, 3'd4, 5'd7, 5'd0, 5'd0, 1'b1);
    #1 chk("slot_div_ready", 64'(issue_ready), 64'd1);
    push(1'b0, 3'd4, 5'd7);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      present(1'b1, 3'd0, 5'd8, 5'd0, 5'd0, k == 5);
      #1 chk("slot_mul_ready", 64'(issue_ready), 64'(k != 4));
    end
    push(1'b1, 3'd0, 5'd8);
    for (int k = 6; k <= 9; k++) begin
      @(negedge clk);
      if (k == 6) idle();
      #1;
      if (k == 8)      chk("slot_div_wb", 64'({wb_valid, wb_is_mul, wb_rd}), 64'({1'b1, 1'b0, 5'd7}));
      else if (k == 9) chk("slot_mul_wb", 64'({wb_valid, wb_is_mul, wb_rd}), 64'({1'b1, 1'b1, 5'd8}));
      else             chk("slot_quiet",  64'(wb_valid), 64'd0);
    end
    repeat (2) @(negedge clk);

    // RAW (rs1=rd) then WAW (rd=rd) against a retiring MUL.
    @(negedge clk);
    hazard_seq(5'd3, 5'd4);
    @(negedge clk);
    hazard_seq(5'd0, 5'd3);

    // Writeback backpressure for 3 cycles while a DIV is in flight.
    @(negedge clk);
    present(1'b1, 3'd1, 5'd10, 5'd0, 5'd0, 1'b1);
    #1 chk("stall_mul_ready", 64'(issue_ready), 64'd1);
    push(1'b1, 3'd1, 5'd10);
    @(negedge clk);
    present(1'b0, 3'd5, 5'd11, 5'd0, 5'd0, 1'b1);
    #1 chk("stall_div_ready", 64'(issue_ready), 64'd1);
    push(1'b0, 3'd5, 5'd11);
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) idle();
      wb_ready = !(k >= 4 && k <= 6);
      #1;
      if (k >= 4 && k <= 7)
        chk("stall_mul_held", 64'({wb_valid, wb_is_mul, wb_funct3, wb_rd}), 64'({1'b1, 1'b1, 3'd1, 5'd10}));
      if (k >= 4 && k <= 6) chk("stall_issue_ready", 64'(issue_ready), 64'd0);
      if (k == 7)           chk("stall_release_ready", 64'(issue_ready), 64'd1);
      if (k >= 8 && k <= 11) chk("stall_div_delayed", 64'(wb_valid), 64'd0);
      if (k == 12)
        chk("stall_div_wb", 64'({wb_valid, wb_is_mul, wb_rd}), 64'({1'b1, 1'b0, 5'd11}));
    end
    wb_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Flush with two MULs and one DIV in flight plus a simultaneous issue.
    @(negedge clk);
    present(1'b1, 3'd0, 5'd12, 5'd0, 5'd0, 1'b1);
    #1 chk("flush_op1_ready", 64'(issue_ready), 64'd1);
    @(negedge clk);
    present(1'b1, 3'd0, 5'd13, 5'd0, 5'd0, 1'b1);
    #1 chk("flush_op2_ready", 64'(issue_ready), 64'd1);
    @(negedge clk);
    present(1'b0, 3'd4, 5'd14, 5'd0, 5'd0, 1'b1);
    #1 chk("flush_op3_ready", 64'(issue_ready), 64'd1);
    @(negedge clk);
    present(1'b1, 3'd0, 5'd15, 5'd0, 5'd0, 1'b1);
    flush = 1'b1;
    #1 chk("flush_issue_blocked", 64'(issue_ready), 64'd0);
    chk("flush_busy_before", 64'(busy_vec), 64'h0000_7000);
    @(negedge clk);
    flush = 1'b0;
    idle();
    #1;
    chk("flush_mdu_busy", 64'(mdu_busy), 64'd0);
    chk("flush_busy_vec", 64'(busy_vec), 64'd0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      #1 if (wb_valid) seen = 1'b1;
    end
    chk("flush_no_wb", 64'(seen), 64'd0);

    // Asynchronous reset with a DIV in flight.
    @(negedge clk);
    present(1'b0, 3'd2, 5'd20, 5'd0, 5'd0, 1'b1);
    #1 chk("rst_mid_ready", 64'(issue_ready), 64'd1);
    @(negedge clk);
    idle();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy_vec", 64'(busy_vec), 64'd0);
    chk("rst_mid_mdu_busy", 64'(mdu_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      #1 if (wb_valid) seen = 1'b1;
    end
    chk("rst_mid_no_wb", 64'(seen), 64'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
